// File: rtl/hilo_mult_if.sv
// Bus bundle for the HI/LO multiply unit: multu operands and start, mthi/mtlo
// moves, and the Hi/Lo/status readback used by the writeback select path.
interface hilo_mult_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             Start;
  logic             WrHi;
  logic             WrLo;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             Busy;
  logic             Done;

  modport master (
    output dataA, dataB, Start, WrHi, WrLo, WrData,
    input  HiOut, LoOut, Busy, Done
  );

  modport slave (
    input  dataA, dataB, Start, WrHi, WrLo, WrData,
    output HiOut, LoOut, Busy, Done
  );
endinterface

// File: rtl/hilo_mult.sv
// Sequential unsigned multiplier owning the Hi/Lo register pair: one shift-add
// step per cycle, result committed to Hi/Lo atomically on the final step.
module hilo_mult #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  hilo_mult_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // Right-shifting accumulator: add the multiplicand into the upper half when
  // the current multiplier bit is set, then shift the whole pair right by one.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = bus.dataA;
          b_d     = bus.dataB;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          if (bus.WrHi) hi_d = bus.WrData;
          if (bus.WrLo) lo_d = bus.WrData;
        end
      end
      RUN: begin
        acc_d = acc_step;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          lo_d    = acc_step[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decodes straight from the state register, so reset clears them at once.
  assign bus.Busy  = (state_q != IDLE);
  assign bus.Done  = (state_q == DONE);
  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;
endmodule

// File: tb/tb_hilo_mult.sv
// Directed self-checking bench for hilo_mult: reset, multiply timing, operand
// extremes, busy interlock, mid-operation reset and move/Start priority.
module tb_hilo_mult;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  hilo_mult_if #(.WIDTH(W)) bus ();

  hilo_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives Start for one edge; returns at the negedge of cycle 1 after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.dataA = a;
    bus.dataB = b;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Called at cycle 1; walks negedges until Busy drops, bounded.
  task automatic wait_idle(output int busy_cycles, output int pulses, output int done_at);
    int cyc;
    cyc     = 1;
    pulses  = 0;
    done_at = 0;
    while (bus.Busy && cyc < 200) begin
      if (bus.Done) begin
        pulses++;
        done_at = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    busy_cycles = cyc - 1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.HiOut !== '0 || bus.LoOut !== '0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b, required all zero",
               bus.HiOut, bus.LoOut, bus.Busy, bus.Done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_small;
    int hold_bad;
    int busy_bad;
    // Preload distinctive Hi/Lo so a partial update during RUN is visible.
    @(negedge clk);
    bus.WrHi = 1'b1; bus.WrLo = 1'b1; bus.WrData = 32'h0000_AAAA;
    @(negedge clk);
    bus.WrHi = 1'b0; bus.WrLo = 1'b0;
    tests++;
    if (bus.HiOut !== 32'h0000_AAAA || bus.LoOut !== 32'h0000_AAAA) begin
      fails++;
      $display("FAIL dual_move: hi=%h lo=%h, required 0000aaaa/0000aaaa", bus.HiOut, bus.LoOut);
    end
    start_op(32'd3, 32'd5);
    hold_bad = 0;
    busy_bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (bus.HiOut !== 32'h0000_AAAA || bus.LoOut !== 32'h0000_AAAA) hold_bad++;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    tests++;
    if (hold_bad != 0) begin
      fails++;
      $display("FAIL small_hold: %0d cycles with changed Hi/Lo during RUN, required 0", hold_bad);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL small_run_status: %0d bad Busy/Done cycles in 1..32, required 0", busy_bad);
    end
    tests++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b1) begin
      fails++;
      $display("FAIL small_done_cycle33: busy=%b done=%b, required 1/1", bus.Busy, bus.Done);
    end
    tests++;
    if (bus.HiOut !== 32'h0 || bus.LoOut !== 32'h0000_000F) begin
      fails++;
      $display("FAIL small_result: hi=%h lo=%h, required 00000000/0000000f", bus.HiOut, bus.LoOut);
    end
    @(negedge clk);
    tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      fails++;
      $display("FAIL small_idle_after: busy=%b done=%b, required 0/0", bus.Busy, bus.Done);
    end
  endtask

  task automatic test_max;
    int bc, pc, da;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(bc, pc, da);
    tests++;
    if (bus.HiOut !== 32'hFFFF_FFFE || bus.LoOut !== 32'h0000_0001) begin
      fails++;
      $display("FAIL max_result: hi=%h lo=%h, required fffffffe/00000001", bus.HiOut, bus.LoOut);
    end
    tests++;
    if (bc != 33 || pc != 1 || da != 33) begin
      fails++;
      $display("FAIL max_timing: busy=%0d pulses=%0d done_at=%0d, required 33/1/33", bc, pc, da);
    end
  endtask

  task automatic test_interlock;
    int cyc, pulses, done_at;
    start_op(32'h8000_0000, 32'd2);
    cyc = 1; pulses = 0; done_at = 0;
    while (bus.Busy && cyc < 200) begin
      if (bus.Done) begin
        pulses++;
        done_at = cyc;
      end
      if (cyc == 5) begin
        bus.Start = 1'b1; bus.dataA = 32'd7; bus.dataB = 32'd7;
        bus.WrHi = 1'b1; bus.WrData = 32'h0000_DEAD;
      end else begin
        bus.Start = 1'b0; bus.WrHi = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.Start = 1'b0; bus.WrHi = 1'b0;
    tests++;
    if (bus.HiOut !== 32'h0000_0001 || bus.LoOut !== 32'h0) begin
      fails++;
      $display("FAIL interlock_result: hi=%h lo=%h, required 00000001/00000000", bus.HiOut, bus.LoOut);
    end
    tests++;
    if (pulses != 1 || done_at != 33) begin
      fails++;
      $display("FAIL interlock_done: pulses=%0d done_at=%0d, required 1/33", pulses, done_at);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (bus.Busy !== 1'b0 || bus.HiOut !== 32'h0000_0001) begin
      fails++;
      $display("FAIL interlock_no_queue: busy=%b hi=%h, required 0/00000001", bus.Busy, bus.HiOut);
    end
  endtask

  task automatic test_mid_reset;
    int bc, pc, da;
    @(negedge clk);
    bus.WrHi = 1'b1; bus.WrData = 32'h0000_1111;
    @(negedge clk);
    bus.WrHi = 1'b0; bus.WrLo = 1'b1; bus.WrData = 32'h0000_2222;
    @(negedge clk);
    bus.WrLo = 1'b0;
    tests++;
    if (bus.HiOut !== 32'h0000_1111 || bus.LoOut !== 32'h0000_2222) begin
      fails++;
      $display("FAIL preload: hi=%h lo=%h, required 00001111/00002222", bus.HiOut, bus.LoOut);
    end
    start_op(32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.HiOut !== '0 || bus.LoOut !== '0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: hi=%h lo=%h busy=%b done=%b, required all zero",
               bus.HiOut, bus.LoOut, bus.Busy, bus.Done);
    end
    @(negedge clk);
    tests++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.LoOut !== '0) begin
      fails++;
      $display("FAIL reset_hold: busy=%b done=%b lo=%h, required 0/0/0", bus.Busy, bus.Done, bus.LoOut);
    end
    // Start offered together with reset release: the very first edge must accept it.
    rst = 1'b0;
    bus.dataA = 32'd9; bus.dataB = 32'd9; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    tests++;
    if (bus.Busy !== 1'b1) begin
      fails++;
      $display("FAIL first_edge_start: busy=%b, required 1", bus.Busy);
    end
    wait_idle(bc, pc, da);
    tests++;
    if (bus.HiOut !== 32'h0 || bus.LoOut !== 32'h0000_0051 || pc != 1 || da != 33) begin
      fails++;
      $display("FAIL restart_9x9: hi=%h lo=%h pulses=%0d done_at=%0d, required 0/51/1/33",
               bus.HiOut, bus.LoOut, pc, da);
    end
  endtask

  task automatic test_move_priority;
    int bc, pc, da;
    @(negedge clk);
    bus.WrHi = 1'b1; bus.WrData = 32'h0000_BEEF;
    @(negedge clk);
    bus.WrHi = 1'b0; bus.WrLo = 1'b1; bus.WrData = 32'h0000_1234;
    @(negedge clk);
    bus.WrLo = 1'b0;
    tests++;
    if (bus.LoOut !== 32'h0000_1234 || bus.HiOut !== 32'h0000_BEEF) begin
      fails++;
      $display("FAIL mtlo: hi=%h lo=%h, required 0000beef/00001234", bus.HiOut, bus.LoOut);
    end
    @(negedge clk);
    bus.dataA = 32'h0001_0000; bus.dataB = 32'h0003_0000; bus.Start = 1'b1;
    bus.WrHi = 1'b1; bus.WrData = 32'h0000_CAFE;
    @(negedge clk);
    bus.Start = 1'b0; bus.WrHi = 1'b0;
    tests++;
    if (bus.HiOut !== 32'h0000_BEEF || bus.Busy !== 1'b1) begin
      fails++;
      $display("FAIL start_beats_wrhi: hi=%h busy=%b, required 0000beef/1", bus.HiOut, bus.Busy);
    end
    wait_idle(bc, pc, da);
    tests++;
    if (bus.HiOut !== 32'h0000_0003 || bus.LoOut !== 32'h0) begin
      fails++;
      $display("FAIL priority_result: hi=%h lo=%h, required 00000003/00000000", bus.HiOut, bus.LoOut);
    end
  endtask

  task automatic test_back_to_back;
    int bc, pc, da;
    start_op(32'hFFFF_FFFF, 32'd2);
    wait_idle(bc, pc, da);
    tests++;
    if (bus.HiOut !== 32'h0000_0001 || bus.LoOut !== 32'hFFFF_FFFE || bc != 33) begin
      fails++;
      $display("FAIL b2b_first: hi=%h lo=%h busy=%0d, required 00000001/fffffffe/33",
               bus.HiOut, bus.LoOut, bc);
    end
    // Immediate restart on the first IDLE cycle; zero operand clears both halves.
    bus.dataA = 32'h0; bus.dataB = 32'hFFFF_FFFF; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_idle(bc, pc, da);
    tests++;
    if (bus.HiOut !== 32'h0 || bus.LoOut !== 32'h0 || pc != 1 || da != 33) begin
      fails++;
      $display("FAIL b2b_zero: hi=%h lo=%h pulses=%0d done_at=%0d, required 0/0/1/33",
               bus.HiOut, bus.LoOut, pc, da);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.dataA = '0; bus.dataB = '0; bus.Start = 1'b0;
    bus.WrHi = 1'b0; bus.WrLo = 1'b0; bus.WrData = '0;
    test_reset();
    test_small();
    test_max();
    test_interlock();
    test_mid_reset();
    test_move_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hilo_mult.md
HILO_MULT -- requirements
Module: hilo_mult

Interface
REQ-001 Parameter WIDTH, default 32, operand width; HiOut/LoOut are each WIDTH bits, and the internal iteration counter is sized to hold WIDTH.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port dataA, input, WIDTH: multiplicand (unsigned), sampled only on the accepting edge of Start.
REQ-005 Port dataB, input, WIDTH: multiplier (unsigned), sampled only on the accepting edge of Start.
REQ-006 Port Start, input, 1: request a multu; accepted only in IDLE.
REQ-007 Port WrHi, input, 1: mthi write enable; WrData loads Hi.
REQ-008 Port WrLo, input, 1: mtlo write enable; WrData loads Lo.
REQ-009 Port WrData, input, WIDTH: data for mthi/mtlo.
REQ-010 Port HiOut, output, WIDTH: Hi register, feeds the writeback select path for mfhi.
REQ-011 Port LoOut, output, WIDTH: Lo register, feeds the writeback select path for mflo.
REQ-012 Port Busy, output, 1: high whenever state is not IDLE; the pipeline stalls mfhi/mflo/multu while high.
REQ-013 Port Done, output, 1: one-cycle pulse when new Hi/Lo become visible.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE with Start=1 at edge k: latch dataA/dataB, clear the 2*WIDTH accumulator and counter, and go to RUN.
REQ-016 RUN SHALL perform one shift-add iteration per cycle for exactly WIDTH cycles, at edges k+1..k+WIDTH.
REQ-017 Edge k+WIDTH SHALL write the product upper half to Hi and lower half to Lo atomically, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle: Done=1 for that cycle, then IDLE at edge k+WIDTH+1.
REQ-019 Result SHALL equal the full unsigned 2*WIDTH-bit product; no truncation, no overflow flag.
REQ-020 HiOut/LoOut SHALL hold their previous values throughout RUN, so a reader never sees a partial product.
REQ-021 Start while Busy=1 SHALL be ignored; the in-flight operation and its operands are unaffected.
REQ-022 In IDLE, WrHi/WrLo SHALL update Hi/Lo at the next edge, visible the following cycle; both may be asserted together.
REQ-023 WrHi/WrLo while Busy=1 SHALL be ignored.
REQ-024 Start with WrHi/WrLo in the same IDLE cycle: Start wins and the writes are discarded.
REQ-025 Done SHALL never be high in IDLE or RUN; Busy SHALL be low only in IDLE.

Reset
REQ-026 While rst is high, asynchronously and regardless of clk: HiOut=0, LoOut=0, Busy=0, Done=0, state=IDLE, counter and accumulator=0.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort the operation with no Hi/Lo update and no Done pulse.
REQ-028 After rst deasserts, the first rising edge SHALL be able to accept Start.

Verification
REQ-029 Reset check: assert rst with no clock edge -> HiOut=0, LoOut=0, Busy=0, Done=0 immediately.
REQ-030 Small multiply: dataA=3, dataB=5, Start one cycle -> Busy=1 for 33 cycles; Done pulses on cycle 33 after Start; Hi=0x00000000, Lo=0x0000000F; Hi/Lo unchanged during cycles 1-32.
REQ-031 Maximum operands: dataA=dataB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-032 Busy interlock:
- First operation: start 0x80000000 x 2.
- At RUN cycle 5, assert Start with 7 x 7 and WrHi with 0xDEAD.
- Required: Hi=0x00000001, Lo=0x00000000; only one Done pulse.
REQ-033 Mid-operation reset:
- Preload Hi=0x1111 and Lo=0x2222 via WrHi/WrLo.
- Start 9 x 9, then assert rst at RUN cycle 10.
- Required: outputs 0, IDLE, no Done pulse.
- A subsequent start of 9 x 9 yields Lo=0x51.
REQ-034 Move and priority:
- In IDLE, WrLo=1 with WrData=0x1234 -> LoOut=0x1234 next cycle, HiOut unchanged.
- Start and WrHi asserted in the same IDLE cycle -> Hi ends equal to the product upper half, not WrData.
